// File: rtl/memory_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// memory_arbiter_pkg
// Shared types for the cache/RAM arbiter: data word type, RAM controller
// status encoding, arbiter state encoding, default widths and the grant
// selection helper used in every arbitration cycle.
// ---------------------------------------------------------------------------
package memory_arbiter_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_WORD_W     = 32;
  localparam int DEF_STARVE_MAX = 4;

  typedef logic [DEF_WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

  // dcache wins a tie unless the icache has been starved long enough.
  function automatic arb_state_t arb_pick(input logic ireq, input logic dreq,
                                          input logic starved);
    arb_state_t pick;
    if (ireq && dreq) begin
      pick = starved ? IGNT : DGNT;
    end else if (ireq) begin
      pick = IGNT;
    end else if (dreq) begin
      pick = DGNT;
    end else begin
      pick = IDLE;
    end
    return pick;
  endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// ---------------------------------------------------------------------------
// memory_arbiter_if
// Bundles the icache, dcache and RAM-controller signals seen by the arbiter.
//   icache : iREN, iaddr (to arbiter); iload, iwait (from arbiter)
//   dcache : dREN, dWEN, daddr, dstore (to arbiter); dload, dwait (from arbiter)
//   RAM    : ramREN, ramWEN, ramaddr, ramstore (from arbiter);
//            ramload, ramstate (to arbiter)
// Modport slave is the arbiter's view; master is the environment's view.
// ---------------------------------------------------------------------------
interface memory_arbiter_if #(
  parameter int ADDR_W = memory_arbiter_pkg::DEF_ADDR_W,
  parameter int WORD_W = memory_arbiter_pkg::DEF_WORD_W
);
  import memory_arbiter_pkg::*;

  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic [WORD_W-1:0] iload;
  logic              iwait;

  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic [WORD_W-1:0] dload;
  logic              dwait;

  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  ramstate_t         ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/memory_arbiter.sv
// ---------------------------------------------------------------------------
// memory_arbiter
// Shares the single RAM port between the icache fill path and the dcache
// fill/writeback path. The grant is registered (IDLE/IGNT/DGNT); while a
// grant is held the RAM is driven combinationally from the granted cache's
// live request so a dropped request removes the RAM enable immediately.
// dcache has priority; a starvation counter forces an icache grant after
// STARVE_MAX consecutive denied icache-request cycles.
// Ports:
//   CLK  : system clock, rising edge
//   nRST : asynchronous active-low reset
//   bus  : memory_arbiter_if.slave (icache, dcache and RAM controller signals)
// ---------------------------------------------------------------------------
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic               CLK,
  input  logic               nRST,
  memory_arbiter_if.slave    bus
);

  localparam int               CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  arb_state_t       r_state;
  logic [CNT_W-1:0] r_starve_cnt;

  arb_state_t       w_nxtstate;
  logic [CNT_W-1:0] w_starve_nxt;
  logic             w_dreq;
  logic             w_access;
  logic             w_icomplete;
  logic             w_dcomplete;
  logic             w_rearb;

  // Grant state and icache starvation counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_nxtstate;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  // RAM steering, wait generation and next-grant selection.
  always_comb begin
    w_dreq       = bus.dREN | bus.dWEN;
    w_access     = (bus.ramstate == ACCESS);
    w_icomplete  = (r_state == IGNT) & bus.iREN & w_access;
    w_dcomplete  = (r_state == DGNT) & w_dreq & w_access;

    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    w_rearb      = 1'b0;

    case (r_state)
      IDLE: begin
        w_rearb = 1'b1;
      end
      IGNT: begin
        bus.ramREN  = bus.iREN;
        bus.ramaddr = bus.iaddr;
        // Completion or a flushed request both free the port this cycle.
        w_rearb     = w_icomplete | ~bus.iREN;
      end
      DGNT: begin
        // A write wins when the dcache asserts both enables.
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        w_rearb      = w_dcomplete | ~w_dreq;
      end
      default: begin
        w_rearb = 1'b1;
      end
    endcase

    bus.iwait = bus.iREN & ~w_icomplete;
    bus.dwait = w_dreq & ~w_dcomplete;
    bus.iload = bus.ramload;
    bus.dload = bus.ramload;

    if (w_rearb) begin
      w_nxtstate = arb_pick(bus.iREN, w_dreq, r_starve_cnt == STARVE_LIM);
    end else begin
      w_nxtstate = r_state;
    end

    if (bus.iREN && !w_icomplete) begin
      if (r_starve_cnt == STARVE_LIM) begin
        w_starve_nxt = r_starve_cnt;
      end else begin
        w_starve_nxt = r_starve_cnt + CNT_W'(1);
      end
    end else begin
      w_starve_nxt = '0;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int STARVE_MAX = 4;
  localparam int OWN_NONE   = 0;
  localparam int OWN_I      = 1;
  localparam int OWN_D      = 2;

  logic CLK = 1'b0;
  logic nRST;
  int   checks = 0;
  int   errors = 0;

  // reference model: who owns the RAM port and how long icache has waited
  int   m_owner  = OWN_NONE;
  int   m_starve = 0;

  always #5 CLK = ~CLK;

  memory_arbiter_if bus ();

  memory_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  typedef struct {
    logic        iren;
    logic [31:0] iaddr;
    logic        dren;
    logic        dwen;
    logic [31:0] daddr;
    logic [31:0] dstore;
    ramstate_t   rs;
    logic [31:0] rl;
    logic        e_ren;
    logic        e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_store;
    logic        e_iw;
    logic        e_dw;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] ds, input ramstate_t rs,
                       input logic [31:0] rl);
    bus.iREN     = ir;
    bus.iaddr    = ia;
    bus.dREN     = dr;
    bus.dWEN     = dw;
    bus.daddr    = da;
    bus.dstore   = ds;
    bus.ramstate = rs;
    bus.ramload  = rl;
  endtask

  // expected outputs from the owner + the live inputs
  task automatic check_model(input string tag);
    logic        e_ren, e_wen, e_iw, e_dw, dreq, acc;
    logic [31:0] e_addr, e_store;
    dreq    = bus.dREN | bus.dWEN;
    acc     = (bus.ramstate == ACCESS);
    e_ren   = 1'b0;
    e_wen   = 1'b0;
    e_addr  = 32'h0;
    e_store = 32'h0;
    if (m_owner == OWN_I) begin
      e_ren  = bus.iREN;
      e_addr = bus.iaddr;
    end else if (m_owner == OWN_D) begin
      e_wen   = bus.dWEN;
      e_ren   = bus.dREN && !bus.dWEN;
      e_addr  = bus.daddr;
      e_store = bus.dstore;
    end
    e_iw = bus.iREN && !(m_owner == OWN_I && acc);
    e_dw = dreq && !(m_owner == OWN_D && acc);
    check({tag, ".ramREN"},   32'(bus.ramREN),   32'(e_ren));
    check({tag, ".ramWEN"},   32'(bus.ramWEN),   32'(e_wen));
    check({tag, ".ramaddr"},  bus.ramaddr,       e_addr);
    check({tag, ".ramstore"}, bus.ramstore,      e_store);
    check({tag, ".iwait"},    32'(bus.iwait),    32'(e_iw));
    check({tag, ".dwait"},    32'(bus.dwait),    32'(e_dw));
    check({tag, ".iload"},    bus.iload,         bus.ramload);
    check({tag, ".dload"},    bus.dload,         bus.ramload);
  endtask

  // advance the model with the inputs present at the clock edge
  task automatic model_update();
    logic ireq, dreq, acc, idone, ddone, dropped;
    ireq    = bus.iREN;
    dreq    = bus.dREN | bus.dWEN;
    acc     = (bus.ramstate == ACCESS);
    idone   = (m_owner == OWN_I) && ireq && acc;
    ddone   = (m_owner == OWN_D) && dreq && acc;
    dropped = ((m_owner == OWN_I) && !ireq) || ((m_owner == OWN_D) && !dreq);
    if (m_owner == OWN_NONE || idone || ddone || dropped) begin
      if (ireq && dreq) m_owner = (m_starve >= STARVE_MAX) ? OWN_I : OWN_D;
      else if (ireq)    m_owner = OWN_I;
      else if (dreq)    m_owner = OWN_D;
      else              m_owner = OWN_NONE;
    end
    if (ireq && !idone) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
    else                m_starve = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          dgrants;
    int          last_cnt;
    logic        seen;
    logic        ir, dr, dw;
    logic [1:0]  rsv;

    nRST = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
    #2;
    check("reset.ramREN",  32'(bus.ramREN),  32'h0);
    check("reset.ramWEN",  32'(bus.ramWEN),  32'h0);
    check("reset.ramaddr", bus.ramaddr,      32'h0);
    check("reset.state",   32'(dut.r_state), 32'(IDLE));
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    // ---------------- table-driven vectors ----------------
    vecs[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,  32'h0,        FREE,   32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0};
    vecs[1] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,  32'h0,        BUSY,   32'h0,        1'b1, 1'b0, 32'h100, 32'h0,        1'b1, 1'b0};
    vecs[2] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,  32'h0,        BUSY,   32'h0,        1'b1, 1'b0, 32'h100, 32'h0,        1'b1, 1'b0};
    vecs[3] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,  32'h0,        ACCESS, 32'hDEADBEEF, 1'b1, 1'b0, 32'h100, 32'h0,        1'b0, 1'b0};
    vecs[4] = '{1'b0, 32'h100, 1'b1, 1'b1, 32'h40, 32'h12345678, BUSY,   32'h0,        1'b0, 1'b0, 32'h100, 32'h0,        1'b0, 1'b1};
    vecs[5] = '{1'b0, 32'h100, 1'b1, 1'b1, 32'h40, 32'h12345678, FREE,   32'h0,        1'b0, 1'b1, 32'h40,  32'h12345678, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 32'h100, 1'b1, 1'b1, 32'h40, 32'h12345678, ACCESS, 32'hCAFEF00D, 1'b0, 1'b1, 32'h40,  32'h12345678, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 32'h100, 1'b0, 1'b0, 32'h40, 32'h12345678, FREE,   32'h0,        1'b0, 1'b0, 32'h40,  32'h12345678, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  32'h0,        FREE,   32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0};

    for (int v = 0; v < 9; v++) begin
      drive(vecs[v].iren, vecs[v].iaddr, vecs[v].dren, vecs[v].dwen,
            vecs[v].daddr, vecs[v].dstore, vecs[v].rs, vecs[v].rl);
      @(negedge CLK);
      check($sformatf("vec%0d.ramREN", v),   32'(bus.ramREN), 32'(vecs[v].e_ren));
      check($sformatf("vec%0d.ramWEN", v),   32'(bus.ramWEN), 32'(vecs[v].e_wen));
      check($sformatf("vec%0d.ramaddr", v),  bus.ramaddr,     vecs[v].e_addr);
      check($sformatf("vec%0d.ramstore", v), bus.ramstore,    vecs[v].e_store);
      check($sformatf("vec%0d.iwait", v),    32'(bus.iwait),  32'(vecs[v].e_iw));
      check($sformatf("vec%0d.dwait", v),    32'(bus.dwait),  32'(vecs[v].e_dw));
      check($sformatf("vec%0d.iload", v),    bus.iload,       vecs[v].rl);
      check($sformatf("vec%0d.dload", v),    bus.dload,       vecs[v].rl);
      tick();
    end

    // ---------------- simultaneous requests ----------------
    drive(1'b1, 32'h200, 1'b1, 1'b0, 32'h300, 32'h0, FREE, 32'h0);
    @(negedge CLK); check_model("sim0"); check("sim0.idle_ren", 32'(bus.ramREN), 32'h0);
    tick();
    drive(1'b1, 32'h200, 1'b1, 1'b0, 32'h300, 32'h0, ACCESS, 32'h11112222);
    @(negedge CLK); check_model("sim1");
    check("sim1.state", 32'(dut.r_state), 32'(DGNT));
    check("sim1.ramaddr", bus.ramaddr, 32'h300);
    tick();
    drive(1'b1, 32'h200, 1'b0, 1'b0, 32'h300, 32'h0, FREE, 32'h0);
    @(negedge CLK); check_model("sim2");
    check("sim2.no_idle", 32'(dut.r_state != IDLE), 32'h1);
    tick();
    @(negedge CLK); check_model("sim3");
    check("sim3.state", 32'(dut.r_state), 32'(IGNT));
    check("sim3.ramaddr", bus.ramaddr, 32'h200);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
    tick();
    tick();

    // ---------------- starvation ----------------
    drive(1'b1, 32'h500, 1'b1, 1'b0, 32'h600, 32'h0, ACCESS, 32'h55);
    dgrants  = 0;
    last_cnt = -1;
    seen     = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      check_model($sformatf("starve%0d", c));
      if (dut.r_state == IGNT) begin
        seen = 1'b1;
        break;
      end
      if (dut.r_state == DGNT) dgrants++;
      last_cnt = int'(dut.r_starve_cnt);
      tick();
    end
    check("starve.igrant_seen", 32'(seen), 32'h1);
    check("starve.dgrants",     dgrants,   32'd4);
    check("starve.cnt_before",  last_cnt,  32'd4);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
    tick();
    tick();

    // ---------------- flush ----------------
    drive(1'b1, 32'h700, 1'b0, 1'b0, 32'h0, 32'h0, BUSY, 32'h0);
    @(negedge CLK); check_model("flush0");
    tick();
    @(negedge CLK); check_model("flush1"); check("flush1.ramREN", 32'(bus.ramREN), 32'h1);
    tick();
    drive(1'b0, 32'h700, 1'b0, 1'b0, 32'h0, 32'h0, BUSY, 32'h0);
    @(negedge CLK); check_model("flush2"); check("flush2.ramREN", 32'(bus.ramREN), 32'h0);
    tick();
    @(negedge CLK); check("flush3.state", 32'(dut.r_state), 32'(IDLE));
    tick();

    // ---------------- reset mid-access ----------------
    drive(1'b1, 32'h800, 1'b1, 1'b1, 32'h900, 32'hAAAA5555, BUSY, 32'h0);
    @(negedge CLK); check_model("rst0");
    tick();
    @(negedge CLK); check_model("rst1"); check("rst1.ramWEN", 32'(bus.ramWEN), 32'h1);
    tick();
    @(negedge CLK); check("rst2.ramWEN", 32'(bus.ramWEN), 32'h1);
    #1 nRST = 1'b0;
    #1;
    check("rst.ramWEN",  32'(bus.ramWEN),       32'h0);
    check("rst.ramREN",  32'(bus.ramREN),       32'h0);
    check("rst.ramaddr", bus.ramaddr,           32'h0);
    check("rst.state",   32'(dut.r_state),      32'(IDLE));
    check("rst.starve",  32'(dut.r_starve_cnt), 32'h0);
    check("rst.dwait",   32'(bus.dwait),        32'h1);
    check("rst.iwait",   32'(bus.iwait),        32'h1);
    m_owner  = OWN_NONE;
    m_starve = 0;
    @(posedge CLK); #1;
    check("rst.hold_state", 32'(dut.r_state), 32'(IDLE));
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    tick();

    // ---------------- randomized against the model ----------------
    ir = 1'b0; dr = 1'b0; dw = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(3, 0) == 0) ir = 1'($urandom_range(1, 0));
      if ($urandom_range(3, 0) == 0) dr = 1'($urandom_range(1, 0));
      if ($urandom_range(3, 0) == 0) dw = 1'($urandom_range(1, 0));
      rsv = 2'($urandom_range(3, 0));
      drive(ir, $urandom, dr, dw, $urandom, $urandom, ramstate_t'(rsv), $urandom);
      @(negedge CLK);
      check_model($sformatf("rand%0d", n));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
